cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Shares the single CPU bus port between two masters: M0 = MEM-stage load/store, M1 = IF-stage fetch.
//  Sits between the pipeline memory-access logic and the bus interface.
//  Registered req/grant handshake, ownership state machine, combinational owner-to-bus mux.
//  Watchdog flags a bus error when a granted access waits too long for rdy_.
// PARAMETERS
//  ADDR_W   30   word address width
//  DATA_W   32   data width
//  TMO_CYC  255  wait cycles (as_ low, rdy_ high) before bus_err; range 1..2^16-1
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  mN_req_      in   1       N=0,1; bus request, active-low; held until access done
//  mN_as_       in   1       address strobe, active-low; honoured only while granted
//  mN_rw        in   1       1 = READ, 0 = WRITE
//  mN_addr      in   ADDR_W  word address
//  mN_wr_data   in   DATA_W  write data
//  mN_grnt_     out  1       grant, active-low, registered
//  mN_rdy_      out  1       ready, active-low; owner only, else 1
//  m_rd_data    out  DATA_W  s_rd_data broadcast to both masters
//  s_as_/s_rw/s_addr/s_wr_data  out  1/1/ADDR_W/DATA_W  shared bus, driven from owner
//  s_rd_data    in   DATA_W  bus read data
//  s_rdy_       in   1       bus ready, active-low
//  bus_err      out  1       watchdog timeout, registered, sticky until owner drops req_
// BEHAVIOUR
//  Reset values: state IDLE; m0_grnt_=m1_grnt_=1; bus_err=0; wdt cnt=0; last_owner=M1.
//  Reset is async; it applies immediately, including mid-access. No access completes.
//  States:
//   IDLE -> OWN0/OWN1 on the next edge when any req_ is 0.
//   OWNn -> if mn_req_ = 1: go to the other OWN if that master requests, else IDLE.
//   OWNn holds while mn_req_ = 0.
//  Handoff is direct: no IDLE bubble between owners.
//  Grant latency: req_ falls at edge k; grnt_ is 0 after edge k+1.
//  grnt_ = 0 iff state = OWNn.
//  Bus mux:
//   IDLE: s_as_=1, s_rw=1, s_addr=0, s_wr_data=0.
//   OWNn: s_* = mN_* (combinational).
//   A non-owner's as_ is ignored.
//  Ready: mN_rdy_ = s_rdy_ when OWNn, else 1.
//  Simultaneous requests, fixed priority (no macro): M0 wins in IDLE and at handoff.
//  Owner keeps the bus while its req_ stays 0. No preemption.
//  Watchdog (arb_wdt):
//   cnt increments each cycle owner as_=0 and s_rdy_=1; clears on s_rdy_=0 or ownership change.
//   cnt saturates at TMO_CYC. When cnt reaches TMO_CYC, bus_err<=1 on that edge.
//   bus_err clears when the owner's req_ rises, at the same edge as the release.
//  Width: cnt is $clog2(TMO_CYC+1) bits, unsigned, no wrap.
//  Same-cycle release and other request: grant moves on that edge.
//  Same-cycle release and re-request by the same master: treated as release; re-granted next arbitration.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//   Simultaneous requests go to the master that is not last_owner.
//   last_owner updates on every grant; after reset M0 wins first.
//  Not defined: fixed priority M0 > M1; last_owner logic not built.
// STRUCTURE
//  Shared header (alongside bus.h/cpu.h):
//   ARB_ST_IDLE/OWN0/OWN1 encodings (2 bit), ArbStBus.
//   ARB_OWNER_M0/M1.
//   Reuse ENABLE_/DISABLE_, READ/WRITE from stddef.h.
//  Sub-module arb_wdt: counter + sticky bus_err; inputs clk, reset, run, clr, release.
//  Top holds the FSM, grant registers and mux.
// TESTING
//  T1 reset mid-access:
//   M0 owns, s_as_=0, reset pulses -> same cycle grnt_=1, s_as_=1, bus_err=0.
//  T2 single read:
//   m1_req_=0 at edge 1 -> m1_grnt_=0 after edge 2.
//   m1_addr=30'h100, s_rdy_=0 with data 32'hDEADBEEF -> m1_rdy_=0, m_rd_data=DEADBEEF.
//   m1_req_=1 -> IDLE.
//  T3 contention:
//   Both req_ low together.
//   Fixed build: M0 granted; M1 granted on the edge M0 releases, no idle cycle.
//   RR build: alternate owners over 4 rounds (M0,M1,M0,M1).
//  T4 non-owner isolation:
//   M1 owns; M0 drives as_=0, addr=30'h3FF -> s_addr = M1 addr, m0_rdy_=1 throughout.
//  T5 watchdog, TMO_CYC=4:
//   Owner as_=0, s_rdy_=1 held -> bus_err=1 after the 4th wait edge, stays 1.
//   Owner req_ rises -> bus_err=0 with the release.
//   Repeat with s_rdy_=0 at wait 3 -> no bus_err.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: ownership state encodings,
// owner identifiers and active-low strobe / read-write level names.
package cpu_bus_arbiter_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'b00,
    ARB_ST_OWN0 = 2'b01,
    ARB_ST_OWN1 = 2'b10
  } arb_st_bus_e;

  typedef enum logic {
    ARB_OWNER_M0 = 1'b0,
    ARB_OWNER_M1 = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// One master's side of the arbiter: request/strobe/address/data toward the
// arbiter, grant/ready/read data back. Two instances serve M0 and M1.
interface cpu_bus_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              req_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              grnt_;
  logic              rdy_;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_, as_, rw, addr, wr_data,
    input  grnt_, rdy_, rd_data
  );

  modport slave (
    input  req_, as_, rw, addr, wr_data,
    output grnt_, rdy_, rd_data
  );
endinterface

// File: rtl/cpu_bus_arbiter_arb_wdt.sv
// Bus watchdog: counts owner wait cycles (strobe low, ready high), saturating
// at TMO_CYC, and raises a sticky bus_err that clears only on owner release.
module arb_wdt #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  input  logic owner_release,
  output logic bus_err
);
  localparam int              CNT_W  = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             bus_err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      if (clr)
        cnt_reg <= '0;
      else if (run && cnt_reg != TMO_VAL)
        cnt_reg <= cnt_reg + 1'b1;

      // Error fires on the edge the count lands on TMO_CYC; release always wins.
      if (owner_release)
        bus_err_reg <= 1'b0;
      else if (run && !clr && cnt_reg == TMO_M1)
        bus_err_reg <= 1'b1;
    end
  end

  assign bus_err = bus_err_reg;
endmodule

// File: rtl/cpu_bus_arbiter.sv
// Two-master CPU bus arbiter (M0 = MEM load/store, M1 = IF fetch): ownership FSM,
// registered grants, owner-to-bus mux and watchdog. ARB_ROUND_ROBIN_EN selects round robin.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  cpu_bus_arbiter_if.slave  m0,
  cpu_bus_arbiter_if.slave  m1,
  output logic [DATA_W-1:0] m_rd_data,
  output logic              s_as_,
  output logic              s_rw,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wr_data,
  input  logic [DATA_W-1:0] s_rd_data,
  input  logic              s_rdy_,
  output logic              bus_err
);
  arb_st_bus_e state_reg, state_next;
  logic        m0_grnt_reg, m1_grnt_reg;
  logic        m0_want, m1_want;
  logic        wdt_run, wdt_clr, owner_release;

  assign m0_want = (m0.req_ == ENABLE_);
  assign m1_want = (m1.req_ == ENABLE_);

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_owner_reg <= ARB_OWNER_M1;
    else if (state_next != state_reg && state_next == ARB_ST_OWN0)
      last_owner_reg <= ARB_OWNER_M0;
    else if (state_next != state_reg && state_next == ARB_ST_OWN1)
      last_owner_reg <= ARB_OWNER_M1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ARB_ST_IDLE;
      m0_grnt_reg <= DISABLE_;
      m1_grnt_reg <= DISABLE_;
    end else begin
      state_reg   <= state_next;
      m0_grnt_reg <= (state_next == ARB_ST_OWN0) ? ENABLE_ : DISABLE_;
      m1_grnt_reg <= (state_next == ARB_ST_OWN1) ? ENABLE_ : DISABLE_;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_ST_IDLE: begin
        if (m0_want && m1_want) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_next = (last_owner_reg == ARB_OWNER_M0) ? ARB_ST_OWN1 : ARB_ST_OWN0;
`else
          state_next = ARB_ST_OWN0;
`endif
        end else if (m0_want) begin
          state_next = ARB_ST_OWN0;
        end else if (m1_want) begin
          state_next = ARB_ST_OWN1;
        end
      end
      // Release hands straight to a waiting peer, no idle bubble.
      ARB_ST_OWN0: if (!m0_want) state_next = m1_want ? ARB_ST_OWN1 : ARB_ST_IDLE;
      ARB_ST_OWN1: if (!m1_want) state_next = m0_want ? ARB_ST_OWN0 : ARB_ST_IDLE;
      default:     state_next = ARB_ST_IDLE;
    endcase
  end

  always_comb begin
    s_as_     = DISABLE_;
    s_rw      = READ;
    s_addr    = '0;
    s_wr_data = '0;
    case (state_reg)
      ARB_ST_OWN0: begin
        s_as_     = m0.as_;
        s_rw      = m0.rw;
        s_addr    = m0.addr;
        s_wr_data = m0.wr_data;
      end
      ARB_ST_OWN1: begin
        s_as_     = m1.as_;
        s_rw      = m1.rw;
        s_addr    = m1.addr;
        s_wr_data = m1.wr_data;
      end
      default: ;
    endcase
  end

  assign m0.grnt_   = m0_grnt_reg;
  assign m1.grnt_   = m1_grnt_reg;
  assign m0.rdy_    = (state_reg == ARB_ST_OWN0) ? s_rdy_ : DISABLE_;
  assign m1.rdy_    = (state_reg == ARB_ST_OWN1) ? s_rdy_ : DISABLE_;
  assign m0.rd_data = s_rd_data;
  assign m1.rd_data = s_rd_data;
  assign m_rd_data  = s_rd_data;

  assign wdt_run = (state_reg != ARB_ST_IDLE) && (s_as_ == ENABLE_) && (s_rdy_ == DISABLE_);
  assign wdt_clr = (s_rdy_ == ENABLE_) || (state_next != state_reg);
  assign owner_release = ((state_reg == ARB_ST_OWN0) && !m0_want) ||
                         ((state_reg == ARB_ST_OWN1) && !m1_want);

  arb_wdt #(
    .TMO_CYC (TMO_CYC)
  ) u_wdt (
    .clk           (clk),
    .reset         (reset),
    .run           (wdt_run),
    .clr           (wdt_clr),
    .owner_release (owner_release),
    .bus_err       (bus_err)
  );
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with TMO_CYC=4: reset, single read,
// contention, non-owner isolation, watchdog and asynchronous reset mid-access.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] m_rd_data;
  logic              s_as_;
  logic              s_rw;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy_;
  logic              bus_err;

  int n_cmp;
  int n_mis;

  cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  cpu_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .m_rd_data (m_rd_data),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_addr    (s_addr),
    .s_wr_data (s_wr_data),
    .s_rd_data (s_rd_data),
    .s_rdy_    (s_rdy_),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_if.req_ = 1'b1; m0_if.as_ = 1'b1; m0_if.rw = 1'b1; m0_if.addr = '0; m0_if.wr_data = '0;
    m1_if.req_ = 1'b1; m1_if.as_ = 1'b1; m1_if.rw = 1'b1; m1_if.addr = '0; m1_if.wr_data = '0;
  endtask

  initial begin
    logic exp_m1_wins;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    s_rdy_ = 1'b1;
    s_rd_data = '0;
    idle_masters();
    tick();
    tick();

    // Reset state
    check_eq("rst m0_grnt_", m0_if.grnt_, 1'b1);
    check_eq("rst m1_grnt_", m1_if.grnt_, 1'b1);
    check_eq("rst bus_err", bus_err, 1'b0);
    check_eq("rst s_as_", s_as_, 1'b1);
    check_eq("rst s_rw", s_rw, 1'b1);
    check_eq("rst s_addr", s_addr, 0);
    reset = 1'b0;
    tick();

    // Single read by M1
    m1_if.req_ = 1'b0; m1_if.as_ = 1'b0; m1_if.rw = READ; m1_if.addr = 30'h100;
    #1;
    check_eq("t2 grnt not early", m1_if.grnt_, 1'b1);
    tick();
    check_eq("t2 m1_grnt_", m1_if.grnt_, 1'b0);
    check_eq("t2 m0_grnt_", m0_if.grnt_, 1'b1);
    check_eq("t2 s_addr", s_addr, 30'h100);
    check_eq("t2 s_as_", s_as_, 1'b0);
    s_rdy_ = 1'b0; s_rd_data = 32'hDEADBEEF;
    #1;
    check_eq("t2 m1_rdy_", m1_if.rdy_, 1'b0);
    check_eq("t2 m0_rdy_", m0_if.rdy_, 1'b1);
    check_eq("t2 m_rd_data", m_rd_data, 32'hDEADBEEF);
    check_eq("t2 m1 rd_data", m1_if.rd_data, 32'hDEADBEEF);
    s_rdy_ = 1'b1;
    idle_masters();
    tick();
    check_eq("t2 release grnt_", m1_if.grnt_, 1'b1);
    check_eq("t2 idle s_as_", s_as_, 1'b1);
    check_eq("t2 idle s_addr", s_addr, 0);

    // Contention with direct handoff (last owner M1, so M0 wins in either build)
    m0_if.req_ = 1'b0; m0_if.as_ = 1'b0; m0_if.rw = WRITE; m0_if.addr = 30'h1; m0_if.wr_data = 32'h1234;
    m1_if.req_ = 1'b0; m1_if.as_ = 1'b0; m1_if.addr = 30'h2;
    tick();
    check_eq("t3 m0_grnt_", m0_if.grnt_, 1'b0);
    check_eq("t3 m1_grnt_", m1_if.grnt_, 1'b1);
    check_eq("t3 s_addr", s_addr, 30'h1);
    check_eq("t3 s_rw", s_rw, 1'b0);
    check_eq("t3 s_wr_data", s_wr_data, 32'h1234);
    m0_if.req_ = 1'b1; m0_if.as_ = 1'b1;
    tick();
    check_eq("t3 handoff m1_grnt_", m1_if.grnt_, 1'b0);
    check_eq("t3 handoff m0_grnt_", m0_if.grnt_, 1'b1);
    check_eq("t3 handoff s_addr", s_addr, 30'h2);
    idle_masters();
    tick();

    // Four rounds of simultaneous requests from idle
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_m1_wins = (r % 2 == 1);
`else
      exp_m1_wins = 1'b0;
`endif
      m0_if.req_ = 1'b0; m1_if.req_ = 1'b0;
      tick();
      check_eq($sformatf("t3 round%0d m0_grnt_", r), m0_if.grnt_, exp_m1_wins);
      check_eq($sformatf("t3 round%0d m1_grnt_", r), m1_if.grnt_, !exp_m1_wins);
      m0_if.req_ = 1'b1; m1_if.req_ = 1'b1;
      tick();
    end

    // Non-owner isolation: M1 owns, M0 requests and strobes
    m1_if.req_ = 1'b0; m1_if.as_ = 1'b0; m1_if.addr = 30'h55;
    tick();
    m0_if.req_ = 1'b0; m0_if.as_ = 1'b0; m0_if.addr = 30'h3FF;
    s_rdy_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("t4 c%0d s_addr", i), s_addr, 30'h55);
      check_eq($sformatf("t4 c%0d m0_rdy_", i), m0_if.rdy_, 1'b1);
      check_eq($sformatf("t4 c%0d m0_grnt_", i), m0_if.grnt_, 1'b1);
      tick();
    end
    s_rdy_ = 1'b1;
    m1_if.req_ = 1'b1; m1_if.as_ = 1'b1;
    tick();
    check_eq("t4 handoff m0_grnt_", m0_if.grnt_, 1'b0);
    check_eq("t4 handoff s_addr", s_addr, 30'h3FF);
    idle_masters();
    tick();

    // Watchdog timeout, sticky until release
    m0_if.req_ = 1'b0;
    tick();
    m0_if.as_ = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      tick();
      check_eq($sformatf("t5 wait%0d bus_err", w), bus_err, 1'b0);
    end
    tick();
    check_eq("t5 wait4 bus_err", bus_err, 1'b1);
    tick();
    tick();
    check_eq("t5 sticky bus_err", bus_err, 1'b1);
    s_rdy_ = 1'b0;
    tick();
    s_rdy_ = 1'b1;
    check_eq("t5 sticky after rdy", bus_err, 1'b1);
    m0_if.req_ = 1'b1; m0_if.as_ = 1'b1;
    tick();
    check_eq("t5 release bus_err", bus_err, 1'b0);
    check_eq("t5 release grnt_", m0_if.grnt_, 1'b1);

    // Ready at wait 3 restarts the count
    m0_if.req_ = 1'b0;
    tick();
    m0_if.as_ = 1'b0;
    tick();
    tick();
    s_rdy_ = 1'b0;
    tick();
    s_rdy_ = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      tick();
      check_eq($sformatf("t5b wait%0d bus_err", w), bus_err, 1'b0);
    end
    idle_masters();
    tick();

    // Async reset in the middle of an access that already tripped the watchdog
    m0_if.req_ = 1'b0; m0_if.addr = 30'h77;
    tick();
    m0_if.as_ = 1'b0;
    for (int w = 0; w < 4; w++) tick();
    check_eq("t1 pre s_as_", s_as_, 1'b0);
    check_eq("t1 pre bus_err", bus_err, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t1 m0_grnt_", m0_if.grnt_, 1'b1);
    check_eq("t1 s_as_", s_as_, 1'b1);
    check_eq("t1 s_addr", s_addr, 0);
    check_eq("t1 bus_err", bus_err, 1'b0);
    idle_masters();
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
